// File: rtl/sockit_spi_axi_dma_if.sv
// AXI4 bus bundle between the interconnect and the SPI burst DMA bridge.
// The slave modport is the bridge's view, the master modport the interconnect's.
interface sockit_spi_axi_dma_if #(
    parameter int DW = 32,
    parameter int IW = 4
) ();
    logic [IW-1:0]   AWID;
    logic [7:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [IW-1:0]   BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [IW-1:0]   ARID;
    logic [7:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;
    logic [IW-1:0]   RID;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport slave (
        input  AWID, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/sockit_spi_axi_dma.sv
// AXI4 burst slave feeding the SPI write stream (sdw) and draining the read stream (sdr).
// Write and read paths are independent single-outstanding-burst FSMs.
module sockit_spi_axi_dma #(
    parameter int    DW     = 32,
    parameter int    IW     = 4,
    parameter string ENDIAN = "BIG"
) (
    input  logic                ACLK,
    input  logic                ARESET,
    sockit_spi_axi_dma_if.slave axi,
    output logic                sdw_vld,
    output logic [DW-1:0]       sdw_dat,
    input  logic                sdw_rdy,
    input  logic                sdr_vld,
    input  logic [DW-1:0]       sdr_dat,
    output logic                sdr_rdy
);
    localparam logic [2:0] SIZE   = 3'($clog2(DW/8));
    localparam bit         LE     = (ENDIAN == "LITTLE");
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] WRAP   = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // The stream is MSB-byte-first; little-endian systems see bytes reversed.
    function automatic logic [DW-1:0] f_order(input logic [DW-1:0] d);
        logic [DW-1:0] o;
        o = d;
        if (LE) begin
            for (int i = 0; i < DW/8; i++) o[8*i +: 8] = d[DW-8-8*i +: 8];
        end
        return o;
    endfunction

    wstate_t       r_wstate, w_wnext;
    rstate_t       r_rstate, w_rnext;
    logic          r_live;
    logic [7:0]    r_wcnt, r_rcnt;
    logic          r_wbad, r_werr, r_rbad;
    logic [IW-1:0] r_bid, r_rid;

    logic w_awhs, w_wbeat, w_bhs, w_arhs, w_rbeat, w_awbad, w_arbad;

    assign w_awhs  = axi.AWVALID & axi.AWREADY;
    assign w_wbeat = (r_wstate == W_DATA) & axi.WVALID & axi.WREADY;
    assign w_bhs   = axi.BVALID & axi.BREADY;
    assign w_arhs  = axi.ARVALID & axi.ARREADY;
    assign w_rbeat = (r_rstate == R_DATA) & axi.RVALID & axi.RREADY;
    assign w_awbad = (axi.AWSIZE != SIZE) | (axi.AWBURST == WRAP);
    assign w_arbad = (axi.ARSIZE != SIZE) | (axi.ARBURST == WRAP);

    // r_live keeps both ready outputs low until the first edge after reset release.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_live   <= 1'b0;
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_wcnt   <= '0;
            r_rcnt   <= '0;
            r_wbad   <= 1'b0;
            r_werr   <= 1'b0;
            r_rbad   <= 1'b0;
            r_bid    <= '0;
            r_rid    <= '0;
        end else begin
            r_live   <= 1'b1;
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
            if (w_awhs) begin
                r_bid  <= axi.AWID;
                r_wcnt <= axi.AWLEN;
                r_wbad <= w_awbad;
                r_werr <= w_awbad;
            end else if (w_wbeat) begin
                r_wcnt <= r_wcnt - 8'd1;
                r_werr <= r_werr | ~(&axi.WSTRB) | (axi.WLAST != (r_wcnt == 8'd0));
            end
            if (w_arhs) begin
                r_rid  <= axi.ARID;
                r_rcnt <= axi.ARLEN;
                r_rbad <= w_arbad;
            end else if (w_rbeat) begin
                r_rcnt <= r_rcnt - 8'd1;
            end
        end
    end

    // The write burst ends on its counted final beat whatever WLAST says.
    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_awhs) w_wnext = W_DATA;
            W_DATA:  if (w_wbeat && r_wcnt == 8'd0) w_wnext = W_RESP;
            W_RESP:  if (w_bhs) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_arhs) w_rnext = R_DATA;
            R_DATA:  if (w_rbeat && r_rcnt == 8'd0) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Bad bursts drain W beats and fabricate error R beats without touching the streams.
    always_comb begin
        axi.AWREADY = r_live && (r_wstate == W_IDLE);
        axi.WREADY  = 1'b0;
        sdw_vld     = 1'b0;
        sdw_dat     = f_order(axi.WDATA);
        axi.BVALID  = (r_wstate == W_RESP);
        axi.BRESP   = (r_wstate == W_RESP && r_werr) ? SLVERR : OKAY;
        axi.BID     = r_bid;
        if (r_wstate == W_DATA) begin
            if (r_wbad) begin
                axi.WREADY = 1'b1;
            end else begin
                axi.WREADY = sdw_rdy;
                sdw_vld    = axi.WVALID;
            end
        end

        axi.ARREADY = r_live && (r_rstate == R_IDLE);
        axi.RVALID  = 1'b0;
        axi.RDATA   = '0;
        axi.RRESP   = OKAY;
        axi.RLAST   = 1'b0;
        axi.RID     = r_rid;
        sdr_rdy     = 1'b0;
        if (r_rstate == R_DATA) begin
            axi.RLAST = (r_rcnt == 8'd0);
            if (r_rbad) begin
                axi.RVALID = 1'b1;
                axi.RRESP  = SLVERR;
            end else begin
                axi.RVALID = sdr_vld;
                axi.RDATA  = f_order(sdr_dat);
                sdr_rdy    = axi.RREADY;
            end
        end
    end
endmodule
